op_fetch_decode: RTL
====================

# op_fetch_decode

Sequencer directly downstream of the 8-entry opcode memory. On `start` it walks the memory from entry 0, pulses the memory read strobe, and captures the returned 16-bit op word. It decodes each word into opcode/destination/source fields and hands each command to the matrix execution unit over a valid/ready handshake. It stops on a STOP opcode, after the programmed op count, or on an illegal opcode.

## Interface
Parameters:
- `OP_W`, 16, op word width (fixed layout below; other values unsupported)
- `DEPTH`, 8, opcode memory entries
- `AW`, 3, memory address width, log2(DEPTH)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a program run; sampled only in IDLE
- `opCount`  in  4  number of valid ops, 0..8; values >8 clamp to 8; latched on accepted `start`
- `rCount`  out  AW  opcode memory read address
- `opRead`  out  1  read strobe to memory, one-cycle pulse per fetch
- `opBus`  in  OP_W  op word returned by memory
- `cmd_valid`  out  1  decoded command available
- `cmd_ready`  in  1  execution unit accepts command
- `cmd_opcode`  out  4  op[15:12]
- `cmd_dst`  out  4  op[11:8], destination matrix register
- `cmd_srcA`  out  4  op[7:4]
- `cmd_srcB`  out  4  op[3:0]
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of run
- `illegal`  out  1  sticky; set on illegal opcode, cleared on next accepted `start` or reset

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, FINISH.
- IDLE: on `start`=1, latch the clamped `opCount` into `remaining`, set `idx`=0, clear `illegal`. If the clamped count is 0, go to FINISH. Otherwise go to FETCH.
- FETCH: `rCount`=`idx`, `opRead`=1 for this cycle only. Go to LATCH.
- LATCH: `opRead`=0. Register `opBus` into the command fields. Decode op[15:12] as follows:
  - 0x0 NOP: no issue. Advance (see below).
  - 0x1 ADD, 0x2 SUB, 0x3 SCALE, 0x4 MMUL, 0x5 TRANSPOSE: go to ISSUE.
  - 0xF STOP: go to FINISH without issuing.
  - Any other value: set `illegal`, go to FINISH without issuing.
- ISSUE: `cmd_valid`=1. Fields stay stable until the handshake. On `cmd_valid`&&`cmd_ready`, advance.
- Advance: decrement `remaining` and increment `idx` (3-bit, wraps 7→0). If `remaining` becomes 0, go to FINISH. Otherwise go to FETCH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`=1.
- `rCount` holds its last value outside FETCH.
- `cmd_*` fields hold the last decoded op until the next LATCH.

## Timing
- Reset values:
  - state IDLE
  - `rCount`=0, `opRead`=0
  - `cmd_valid`=0, `cmd_opcode`/`cmd_dst`/`cmd_srcA`/`cmd_srcB`=0
  - `busy`=0, `done`=0, `illegal`=0
- Reset mid-run returns to IDLE on the next edge, drops `cmd_valid` without a handshake, and produces no `done` pulse.
- `start` sampled at edge N: FETCH in cycle N+1 (`opRead` high), LATCH in N+2, `cmd_valid` high in N+3.
- `opBus` is sampled in LATCH, one full cycle after the `opRead` rising edge. The memory updates on that edge.
- With `cmd_ready` tied high, throughput is 3 cycles per issued op and 2 cycles per NOP.
- Handshake: once `cmd_valid` is asserted, it stays high and the fields stay constant until `cmd_ready`=1 at an edge. `cmd_valid` deasserts the cycle after acceptance.
- `done` is asserted in the cycle after the last acceptance, or after LATCH of STOP/illegal.
- `busy` drops in the cycle after `done`.
- A run with `opCount`=0: `busy` high and `done` pulse in N+1, IDLE in N+2.
- `opCount`≥8: all 8 entries are fetched. `idx` ends wrapped to 0, and no entry is read twice.

## Test plan
- Memory loaded with 0x1123, 0x4456, 0x5700, `opCount`=3, `cmd_ready`=1 → three commands in order with fields (1,1,2,3), (4,4,5,6), (5,7,0,0) at cycles N+3, N+6, N+9; `done` at N+10; `illegal`=0.
- Entry 1 = 0xF000 and `opCount`=8 → only entry 0 is issued; `rCount` never exceeds 1; `done` with no second `cmd_valid`.
- Entry 0 = 0x9ABC → `illegal`=1 and `done` pulse with no `cmd_valid`. `illegal` stays 1 until the next `start`, then clears.
- Entry 0 = 0x1123 with `cmd_ready` held low 5 cycles → `cmd_valid` and fields are stable for all 5 cycles; `rCount` does not advance; exactly one acceptance.
- Entry 0 = 0x0000 (NOP), entry 1 = 0x2111, `opCount`=2 → exactly one command, (2,1,1,1); `opRead` pulses twice.
- `reset` asserted while in ISSUE → next cycle all outputs are at reset values. A following `start` with `opCount`=0 gives `done` at N+1 and nothing else.

Source files
------------

// File: rtl/op_fetch_decode.sv
// op_fetch_decode: walks the opcode memory from entry 0 on start, captures
// each returned op word, decodes it and issues arithmetic commands to the
// matrix execution unit. A run ends on STOP, an illegal opcode, or once the
// programmed op count has been consumed.
//
// Command handshake: cmd_valid is raised only in ISSUE and, once raised, stays
// high with cmd_opcode/cmd_dst/cmd_srcA/cmd_srcB constant until a rising edge
// where cmd_ready is 1; that edge is the acceptance and cmd_valid drops in the
// following cycle. cmd_ready has no combinational effect on any output.
module op_fetch_decode #(
    parameter int OP_W  = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      opCount,
    output logic [AW-1:0]   rCount,
    output logic            opRead,
    input  logic [OP_W-1:0] opBus,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [3:0]      cmd_opcode,
    output logic [3:0]      cmd_dst,
    output logic [3:0]      cmd_srcA,
    output logic [3:0]      cmd_srcB,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_SUB   = 4'h2;
    localparam logic [3:0] OPC_SCALE = 4'h3;
    localparam logic [3:0] OPC_MMUL  = 4'h4;
    localparam logic [3:0] OPC_TRANS = 4'h5;
    localparam logic [3:0] OPC_STOP  = 4'hF;

    localparam logic [3:0] MAX_OPS = 4'(DEPTH);

    state_t          state_q, state_d;
    logic [3:0]      remaining_q, remaining_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   rcount_q, rcount_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [3:0]      dst_q, dst_d;
    logic [3:0]      srca_q, srca_d;
    logic [3:0]      srcb_q, srcb_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      count_clamped;
    logic [3:0]      bus_opcode;

    // Requested op counts beyond the memory depth are limited to a full sweep.
    always_comb begin
        count_clamped = (opCount > MAX_OPS) ? MAX_OPS : opCount;
    end

    assign bus_opcode = opBus[15:12];

    // Next-state, counters, field capture and sticky illegal flag.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        opcode_d    = opcode_q;
        dst_d       = dst_q;
        srca_d      = srca_q;
        srcb_d      = srcb_q;
        illegal_d   = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = count_clamped;
                    idx_d       = '0;
                    illegal_d   = 1'b0;
                    state_d     = (count_clamped == 4'd0) ? S_FINISH : S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                // The memory presents the word one cycle after the strobe.
                opcode_d = opBus[15:12];
                dst_d    = opBus[11:8];
                srca_d   = opBus[7:4];
                srcb_d   = opBus[3:0];
                case (bus_opcode)
                    OPC_NOP: begin
                        remaining_d = remaining_q - 4'd1;
                        idx_d       = idx_q + 1'b1;
                        state_d     = (remaining_q == 4'd1) ? S_FINISH : S_FETCH;
                    end
                    OPC_ADD, OPC_SUB, OPC_SCALE, OPC_MMUL, OPC_TRANS: begin
                        state_d = S_ISSUE;
                    end
                    OPC_STOP: begin
                        state_d = S_FINISH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                endcase
            end

            S_ISSUE: begin
                if (cmd_ready) begin
                    remaining_d = remaining_q - 4'd1;
                    idx_d       = idx_q + 1'b1;
                    state_d     = (remaining_q == 4'd1) ? S_FINISH : S_FETCH;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The read address is loaded on entry to FETCH and held otherwise.
    always_comb begin
        rcount_d = rcount_q;
        if (state_d == S_FETCH) begin
            rcount_d = idx_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            rcount_q    <= '0;
            opcode_q    <= '0;
            dst_q       <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            rcount_q    <= rcount_d;
            opcode_q    <= opcode_d;
            dst_q       <= dst_d;
            srca_q      <= srca_d;
            srcb_q      <= srcb_d;
            illegal_q   <= illegal_d;
        end
    end

    assign rCount     = rcount_q;
    assign opRead     = (state_q == S_FETCH);
    assign cmd_valid  = (state_q == S_ISSUE);
    assign cmd_opcode = opcode_q;
    assign cmd_dst    = dst_q;
    assign cmd_srcA   = srca_q;
    assign cmd_srcB   = srcb_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);
    assign illegal    = illegal_q;

endmodule
